pc_unit: RTL and testbench

Parametrised program-counter unit for the fetch stage. It holds the architectural PC register and computes sequential, branch and register-jump next-PC values. It inserts a one-cycle fetch bubble after every redirect and traps misaligned targets to a fixed vector. An optional return-address stack predicts `ret` targets. It sits between the decode/execute redirect signals and the instruction memory address port.

---
 rtl/pc_unit.sv | 144 ++++++++++++++
 tb/tb_pc_unit.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/pc_unit.sv
// Fetch-stage program counter: sequential / branch / jalr next-PC, one-cycle bubble
// after every redirect, misaligned-target trap. Optional return stack under PC_RAS_EN.
module pc_unit #(
    parameter int               XLEN         = 32,
    parameter int               INC          = 4,
    parameter logic [XLEN-1:0]  RESET_VECTOR = '0,
    parameter logic [XLEN-1:0]  TRAP_VECTOR  = XLEN'(32'h0000_0100),
    parameter int               RAS_DEPTH    = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_off,
    input  logic            jump_reg,
    input  logic [XLEN-1:0] jump_base,
    input  logic [XLEN-1:0] jump_off,
    input  logic            call,
    input  logic            ret,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus,
    output logic            fetch_valid,
    output logic            misalign,
    output logic [XLEN-1:0] bad_addr
);

    typedef enum logic {RUN, BUBBLE} state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] bad_addr_q, bad_addr_d;
    logic            misalign_q, misalign_d;

    logic            redirect;
    logic [XLEN-1:0] jalr_sum;
    logic [XLEN-1:0] jalr_tgt;
    logic [XLEN-1:0] br_tgt;
    logic [XLEN-1:0] tgt;
    logic            tgt_mis;
    logic            ret_hit;
    logic [XLEN-1:0] ras_top;

    assign pc_plus  = pc_q + XLEN'(INC);
    assign redirect = jump_reg | branch_taken;
    assign jalr_sum = jump_base + jump_off;
    assign jalr_tgt = {jalr_sum[XLEN-1:1], 1'b0};
    assign br_tgt   = pc_q + branch_off;

`ifdef PC_RAS_EN
    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;

    logic [XLEN-1:0] ras_q [RAS_DEPTH];
    logic [XLEN-1:0] ras_d [RAS_DEPTH];
    logic [PW-1:0]   sp_q, sp_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]   sp_m1;

    assign sp_m1   = sp_q - PW'(1);
    assign ret_hit = jump_reg & ret & (cnt_q != '0);
    assign ras_top = ras_q[sp_m1];

    // Circular stack: sp points at the next free slot; when full it points at the oldest entry.
    always_comb begin
        ras_d = ras_q;
        sp_d  = sp_q;
        cnt_d = cnt_q;
        if (redirect && call) begin
            if (ret_hit) begin
                ras_d[sp_m1] = pc_plus;
            end else begin
                ras_d[sp_q] = pc_plus;
                sp_d        = sp_q + PW'(1);
                if (cnt_q != CW'(RAS_DEPTH)) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
        end else if (ret_hit) begin
            sp_d  = sp_m1;
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sp_q  <= '0;
            cnt_q <= '0;
        end else begin
            sp_q  <= sp_d;
            cnt_q <= cnt_d;
            ras_q <= ras_d;
        end
    end
`else
    logic unused_ras;

    assign ret_hit    = 1'b0;
    assign ras_top    = '0;
    assign unused_ras = call ^ ret ^ (RAS_DEPTH == 0);
`endif

    assign tgt     = jump_reg ? (ret_hit ? ras_top : jalr_tgt) : br_tgt;
    assign tgt_mis = (tgt & XLEN'(INC - 1)) != '0;

    // Redirects win over stall in either state; stall never extends the bubble.
    always_comb begin
        state_d    = RUN;
        pc_d       = pc_q;
        misalign_d = 1'b0;
        bad_addr_d = bad_addr_q;
        if (redirect) begin
            state_d = BUBBLE;
            if (tgt_mis) begin
                pc_d       = TRAP_VECTOR;
                bad_addr_d = tgt;
                misalign_d = 1'b1;
            end else begin
                pc_d = tgt;
            end
        end else if (!stall) begin
            pc_d = pc_plus;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= BUBBLE;
            pc_q       <= RESET_VECTOR;
            misalign_q <= 1'b0;
            bad_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            misalign_q <= misalign_d;
            bad_addr_q <= bad_addr_d;
        end
    end

    assign pc          = pc_q;
    assign fetch_valid = (state_q == RUN);
    assign misalign    = misalign_q;
    assign bad_addr    = bad_addr_q;

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed scenarios plus randomized traffic
// compared against a queue-based behavioural model. Define PC_RAS_EN to cover the return stack.
module tb_pc_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_off = '0;
    logic        jump_reg = 1'b0;
    logic [31:0] jump_base = '0;
    logic [31:0] jump_off = '0;
    logic        call = 1'b0;
    logic        ret = 1'b0;
    logic [31:0] pc;
    logic [31:0] pc_plus;
    logic        fetch_valid;
    logic        misalign;
    logic [31:0] bad_addr;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_pc = '0;
    logic [31:0] m_bad = '0;
    logic        m_valid = 1'b0;
    logic        m_mis = 1'b0;
    logic [31:0] m_ras [$];

    pc_unit dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_off   (branch_off),
        .jump_reg     (jump_reg),
        .jump_base    (jump_base),
        .jump_off     (jump_off),
        .call         (call),
        .ret          (ret),
        .pc           (pc),
        .pc_plus      (pc_plus),
        .fetch_valid  (fetch_valid),
        .misalign     (misalign),
        .bad_addr     (bad_addr)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance the behavioural model by one clock using the architectural rules.
    task automatic stepModel();
        logic [31:0] tgt;
        logic [31:0] link;
        if (rst) begin
            m_pc    = 32'h0;
            m_valid = 1'b0;
            m_mis   = 1'b0;
            m_bad   = 32'h0;
            m_ras.delete();
        end else if (jump_reg || branch_taken) begin
            link = m_pc + 32'd4;
            if (jump_reg) begin
                tgt = (jump_base + jump_off) & 32'hFFFF_FFFE;
`ifdef PC_RAS_EN
                if (ret && m_ras.size() > 0) tgt = m_ras.pop_back();
`endif
            end else begin
                tgt = m_pc + branch_off;
            end
`ifdef PC_RAS_EN
            if (call) begin
                m_ras.push_back(link);
                if (m_ras.size() > 4) void'(m_ras.pop_front());
            end
`endif
            m_valid = 1'b0;
            if (tgt % 4 != 0) begin
                m_pc  = 32'h100;
                m_bad = tgt;
                m_mis = 1'b1;
            end else begin
                m_pc  = tgt;
                m_mis = 1'b0;
            end
        end else begin
            m_valid = 1'b1;
            m_mis   = 1'b0;
            if (!stall) m_pc = m_pc + 32'd4;
        end
    endtask

    task automatic applyStimulus(input logic r, input logic st, input logic bt, input logic [31:0] bo,
                                 input logic jr, input logic [31:0] jb, input logic [31:0] jo,
                                 input logic c, input logic rt);
        @(negedge clk);
        rst          = r;
        stall        = st;
        branch_taken = bt;
        branch_off   = bo;
        jump_reg     = jr;
        jump_base    = jb;
        jump_off     = jo;
        call         = c;
        ret          = rt;
        stepModel();
        @(posedge clk);
        #1;
        checkOutput("pc", pc, m_pc);
        checkOutput("pc_plus", pc_plus, m_pc + 32'd4);
        checkOutput("fetch_valid", {31'b0, fetch_valid}, {31'b0, m_valid});
        checkOutput("misalign", {31'b0, misalign}, {31'b0, m_mis});
        checkOutput("bad_addr", bad_addr, m_bad);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        logic        r, st, bt, jr, c, rt;
        logic [31:0] bo, jb, jo;

        $display("[TB] reset and sequential fetch");
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("reset_pc", pc, 32'h0);
        checkOutput("reset_valid", {31'b0, fetch_valid}, 32'h0);
        checkOutput("reset_bad", bad_addr, 32'h0);
        idle(3);
        checkOutput("seq_pc", pc, 32'hC);
        checkOutput("seq_valid", {31'b0, fetch_valid}, 32'h1);
        idle(1);

        $display("[TB] backward branch");
        applyStimulus(0, 0, 1, 32'hFFFF_FFF8, 0, 0, 0, 0, 0);
        checkOutput("branch_pc", pc, 32'h8);
        checkOutput("branch_bubble", {31'b0, fetch_valid}, 32'h0);
        idle(1);
        checkOutput("branch_after", pc, 32'hC);

        $display("[TB] jalr beats branch");
        applyStimulus(0, 0, 1, 32'h40, 1, 32'h1001, 32'h3, 0, 0);
        checkOutput("jalr_pc", pc, 32'h1004);

        $display("[TB] misaligned branch");
        applyStimulus(0, 0, 1, 32'h2, 0, 0, 0, 0, 0);
        checkOutput("trap_pc", pc, 32'h100);
        checkOutput("trap_pulse", {31'b0, misalign}, 32'h1);
        checkOutput("trap_bad", bad_addr, 32'h1006);
        idle(1);
        checkOutput("trap_pulse_end", {31'b0, misalign}, 32'h0);

        $display("[TB] stall and redirect under stall");
        for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("stall_pc", pc, 32'h104);
        checkOutput("stall_valid", {31'b0, fetch_valid}, 32'h1);
        applyStimulus(0, 1, 0, 0, 1, 32'h80, 32'h0, 0, 0);
        checkOutput("stall_redirect", pc, 32'h80);

        $display("[TB] address wrap");
        applyStimulus(0, 0, 0, 0, 1, 32'hFFFF_FFFC, 32'h0, 0, 0);
        idle(1);
        checkOutput("wrap_pc", pc, 32'h0);

`ifdef PC_RAS_EN
        $display("[TB] return stack");
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 32'h10, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 1, 32'h20, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 1, 32'h30, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 1, 32'h40, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 1, 32'h300, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 1, 32'h200, 0, 0, 1);
        checkOutput("ret1", pc, 32'h44);
        applyStimulus(0, 0, 0, 0, 1, 32'h200, 0, 0, 1);
        checkOutput("ret2", pc, 32'h34);
        applyStimulus(0, 0, 0, 0, 1, 32'h200, 0, 0, 1);
        checkOutput("ret3", pc, 32'h24);
        applyStimulus(0, 0, 0, 0, 1, 32'h200, 0, 0, 1);
        checkOutput("ret4", pc, 32'h14);
        applyStimulus(0, 0, 0, 0, 1, 32'h200, 0, 0, 1);
        checkOutput("ret_empty", pc, 32'h200);
`endif

        $display("[TB] randomized traffic");
        for (int i = 0; i < 600; i++) begin
            r  = ($urandom_range(0, 59) == 0);
            st = ($urandom_range(0, 3) == 0);
            bt = ($urandom_range(0, 4) == 0);
            jr = ($urandom_range(0, 5) == 0);
            c  = ($urandom_range(0, 2) == 0);
            rt = ($urandom_range(0, 2) == 0);
            bo = 32'($urandom_range(0, 64)) * 32'd4;
            if ($urandom_range(0, 1) == 1) bo = -bo;
            if ($urandom_range(0, 7) == 0) bo = bo + 32'($urandom_range(1, 3));
            jb = $urandom;
            if ($urandom_range(0, 3) != 0) jb = jb & 32'hFFFF_FFFC;
            jo = 32'($urandom_range(0, 15));
            applyStimulus(r, st, bt, bo, jr, jb, jo, c, rt);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
